// File: rtl/dma_mem_responder_if.sv
// Request/response channel between a DMA memory port (master) and its memory target (slave).
interface dma_mem_responder_if #(
    parameter int DATAWIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [31:0]          req_addr;
    logic [DATAWIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATAWIDTH-1:0] rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dma_mem_responder.sv
// Single-outstanding RAM target: response WAIT_CYCLES+1 clocks after accept, held until rsp_ready.
// DMA_MEM_ERR_EN: addresses >= DEPTH get an error response instead of aliasing modulo DEPTH.
module dma_mem_responder #(
    parameter int DATAWIDTH   = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    dma_mem_responder_if.slave     io_mem,
    output logic [15:0]            o_txn_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [AW-1:0]         r_idx;
    logic [DATAWIDTH-1:0]  r_wdata;
    logic                  r_rsp_valid;
    logic [DATAWIDTH-1:0]  r_rsp_rdata;
    logic [15:0]           r_txn_count;
    logic [DATAWIDTH-1:0]  r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_go_resp;
    logic                  w_acc_we;
    logic [AW-1:0]         w_acc_idx;
    logic [DATAWIDTH-1:0]  w_acc_wdata;
    logic                  w_acc_err;

    assign w_accept  = io_mem.req_valid && io_mem.req_ready;
    assign w_go_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0));

    // With no wait states the access happens on the accept edge, so take the live request.
    assign w_acc_we    = (r_state == S_IDLE) ? io_mem.req_we                : r_we;
    assign w_acc_idx   = (r_state == S_IDLE) ? io_mem.req_addr[AW-1:0]     : r_idx;
    assign w_acc_wdata = (r_state == S_IDLE) ? io_mem.req_wdata             : r_wdata;

`ifdef DMA_MEM_ERR_EN
    logic r_err;
    logic r_rsp_err;
    logic w_req_err;

    assign w_req_err      = (io_mem.req_addr >= 32'(DEPTH));
    assign w_acc_err      = (r_state == S_IDLE) ? w_req_err : r_err;
    assign io_mem.rsp_err = r_rsp_err;
`else
    logic w_unused_addr;

    assign w_unused_addr  = ^io_mem.req_addr;
    assign w_acc_err      = 1'b0;
    assign io_mem.rsp_err = 1'b0;
`endif

    assign io_mem.req_ready = (r_state == S_IDLE) && !i_rst;
    assign io_mem.rsp_valid = r_rsp_valid;
    assign io_mem.rsp_rdata = r_rsp_rdata;
    assign o_txn_count      = r_txn_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_txn_count <= 16'd0;
`ifdef DMA_MEM_ERR_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= io_mem.req_we;
                        r_idx   <= io_mem.req_addr[AW-1:0];
                        r_wdata <= io_mem.req_wdata;
`ifdef DMA_MEM_ERR_EN
                        r_err   <= w_req_err;
`endif
                        r_state <= S_WAIT;
                        r_cnt   <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (io_mem.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_txn_count <= r_txn_count + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // RAM access on the edge entering RESP; overrides the state chosen above.
            if (w_go_resp) begin
                if (w_acc_we && !w_acc_err) begin
                    r_mem[w_acc_idx] <= w_acc_wdata;
                end
                r_rsp_rdata <= (w_acc_we || w_acc_err) ? '0 : r_mem[w_acc_idx];
                r_rsp_valid <= 1'b1;
`ifdef DMA_MEM_ERR_EN
                r_rsp_err   <= w_acc_err;
`endif
                r_state     <= S_RESP;
            end
        end
    end
endmodule
